display_arbiter: RTL

- Shares the on-board display (HEX3..HEX0, LEDG, LEDR) between two owners: the local clock/DCF77 path and the USB host.
- The host reaches the block as USB device[2], through a byte-wide Wishbone slave port.
- A host write takes ownership of the display. A release command, or a timeout counted in 10 ms ticks, returns the display to the local sources.

---
 rtl/display_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/display_arbiter.sv
// Display arbiter: the local clock/DCF77 path or the USB host (via a byte-wide
// Wishbone slave) drives HEX3..HEX0, LEDG and LEDR; host ownership times out in clk_en ticks.
module display_arbiter #(
  parameter int unsigned TIMEOUT_DEFAULT = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic [6:0] local_hex0,
  input  logic [6:0] local_hex1,
  input  logic [6:0] local_hex2,
  input  logic [6:0] local_hex3,
  input  logic [7:0] local_ledg,
  input  logic [9:0] local_ledr,
  input  logic       wb_cyc,
  input  logic       wb_stb,
  input  logic       wb_we,
  input  logic [2:0] wb_adr,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [7:0] ledg,
  output logic [9:0] ledr,
  output logic       remote_active
);

  typedef enum logic {S_LOCAL = 1'b0, S_REMOTE = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [7:0]  r_timeout;
  logic [7:0]  r_shadow [0:4];
  logic [47:0] r_active;
  logic [7:0]  r_dat_o;
  logic        r_ack;
  logic [6:0]  r_hex0, r_hex1, r_hex2, r_hex3;
  logic [7:0]  r_ledg;
  logic [9:0]  r_ledr;

  logic        w_acc, w_wr, w_rd, w_commit, w_release;
  logic [7:0]  w_rd_data;

  assign w_acc     = wb_cyc & wb_stb & ~r_ack;
  assign w_wr      = w_acc & wb_we;
  assign w_rd      = w_acc & ~wb_we;
  assign w_commit  = w_wr && (wb_adr == 3'd5);
  assign w_release = w_wr && (wb_adr == 3'd7);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) r_shadow[i] <= 8'h00;
      r_active  <= 48'h0;
      r_timeout <= 8'(TIMEOUT_DEFAULT);
    end else if (w_wr) begin
      case (wb_adr)
        3'd0, 3'd1, 3'd2, 3'd3, 3'd4: r_shadow[wb_adr] <= wb_dat_i;
        3'd5: r_active <= {2'b00, wb_dat_i[5:0], r_shadow[4], r_shadow[3],
                           r_shadow[2], r_shadow[1], r_shadow[0]};
        3'd6: r_timeout <= wb_dat_i;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rd_data = 8'h00;
    case (wb_adr)
      3'd0: w_rd_data = r_active[7:0];
      3'd1: w_rd_data = r_active[15:8];
      3'd2: w_rd_data = r_active[23:16];
      3'd3: w_rd_data = r_active[31:24];
      3'd4: w_rd_data = r_active[39:32];
      3'd5: w_rd_data = r_active[47:40];
      3'd6: w_rd_data = r_timeout;
      default: w_rd_data = {7'b0, r_state == S_REMOTE};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack   <= 1'b0;
      r_dat_o <= 8'h00;
    end else begin
      r_ack <= w_acc;
      if (w_rd) r_dat_o <= w_rd_data;
    end
  end

  // cnt==0 while REMOTE means the override was committed with timeout 0: never expires.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_LOCAL: begin
        if (w_commit) begin
          w_state_nxt = S_REMOTE;
          w_cnt_nxt   = r_timeout;
        end
      end
      S_REMOTE: begin
        if (w_release) begin
          w_state_nxt = S_LOCAL;
          w_cnt_nxt   = 8'h00;
        end else if (w_commit) begin
          w_cnt_nxt = r_timeout;
        end else if (clk_en && r_cnt > 8'd1) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else if (clk_en && r_cnt == 8'd1) begin
          w_state_nxt = S_LOCAL;
          w_cnt_nxt   = 8'h00;
        end
      end
      default: w_state_nxt = S_LOCAL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_LOCAL;
      r_cnt   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hex0 <= 7'h7F;
      r_hex1 <= 7'h7F;
      r_hex2 <= 7'h7F;
      r_hex3 <= 7'h7F;
      r_ledg <= 8'h00;
      r_ledr <= 10'h000;
    end else if (r_state == S_REMOTE) begin
      {r_ledr, r_ledg, r_hex3, r_hex2, r_hex1, r_hex0} <= r_active[45:0];
    end else begin
      {r_ledr, r_ledg, r_hex3, r_hex2, r_hex1, r_hex0} <=
        {local_ledr, local_ledg, local_hex3, local_hex2, local_hex1, local_hex0};
    end
  end

  assign wb_dat_o      = r_dat_o;
  assign wb_ack        = r_ack;
  assign hex0          = r_hex0;
  assign hex1          = r_hex1;
  assign hex2          = r_hex2;
  assign hex3          = r_hex3;
  assign ledg          = r_ledg;
  assign ledr          = r_ledr;
  assign remote_active = (r_state == S_REMOTE);

endmodule
